am_sample_feeder: RTL and testbench
===================================

AM_SAMPLE_FEEDER -- requirements
Module: am_sample_feeder

Interface
REQ-001 SHALL have parameter AM_PWM_STEPS, default 64, meaning PWM steps per symbol (power of two, 4..256).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning unsigned audio sample width (>= log2(AM_PWM_STEPS)).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning sample buffer entries (power of two, >= 4).
REQ-004 SHALL have parameter PREFILL, default 8, meaning fill level required before playout starts (1..FIFO_DEPTH).
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  audio sample.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  buffer can accept a sample.
REQ-010 SHALL have port symb_req  input  1  one-cycle pulse at each PWM symbol boundary (modulator symbol tick).
REQ-011 SHALL have port duty  output  log2(AM_PWM_STEPS)  high-step count for the next PWM symbol.
REQ-012 SHALL have port playing  output  1  high in RUN state.
REQ-013 SHALL have port underrun  output  1  sticky underrun flag.
REQ-014 SHALL have port underrun_clr  input  1  clears underrun.
REQ-015 SHALL have port fill_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 SHALL accept a sample when in_valid && in_ready; in_ready = (fill_level != FIFO_DEPTH), combinational from registered count.
REQ-017 SHALL store samples in a circular FIFO with wrapping read/write pointers; order preserved.
REQ-018 SHALL implement FSM states PREFILL and RUN; PREFILL -> RUN when fill_level >= PREFILL; RUN -> PREFILL on underrun.
REQ-019 SHALL, in RUN on symb_req with FIFO non-empty, pop one sample and set duty = sample >> (DATA_WIDTH - log2(AM_PWM_STEPS)) on the next rising edge (latency 1 clock).
REQ-020 SHALL, in RUN on symb_req with FIFO empty, set underrun = 1, load duty with the idle value, and enter PREFILL.
REQ-021 SHALL, in PREFILL on symb_req, pop nothing and load duty with the idle value.
REQ-022 SHALL hold duty constant between symb_req pulses.
REQ-023 SHALL, on simultaneous push and pop, leave fill_level unchanged and accept the push (FIFO non-empty case).
REQ-024 SHALL not bypass: a push in the same cycle as symb_req on an empty FIFO SHALL NOT satisfy that request (underrun raised).
REQ-025 SHALL give underrun_clr lower priority than a new underrun event in the same cycle (flag stays 1).
REQ-026 SHALL ignore in_valid when in_ready is low (no overwrite, no count change).
REQ-027 SHALL assert playing exactly while FSM is in RUN.

Reset
REQ-028 SHALL, while rst = 1, clear FIFO pointers and count (fill_level = 0, in_ready = 1), set FSM to PREFILL, playing = 0, underrun = 0, duty = AM_PWM_STEPS/2.
REQ-029 SHALL discard buffered samples on reset asserted mid-operation; first post-reset duty is AM_PWM_STEPS/2.

Configuration
REQ-030 SHALL support macro AM_FEEDER_HOLD_LAST_EN defined in project defines.
REQ-031 SHALL, with AM_FEEDER_HOLD_LAST_EN defined, use the last duty value as the idle value (midscale only until the first sample after reset).
REQ-032 SHALL, without AM_FEEDER_HOLD_LAST_EN, use AM_PWM_STEPS/2 as the idle value.

Verification (AM_PWM_STEPS=64, DATA_WIDTH=8, FIFO_DEPTH=16, PREFILL=8)
REQ-033 SHALL cover: push 7 samples, pulse symb_req -> playing=0, duty=32, fill_level=7; 8th push -> playing=1 next cycle.
REQ-034 SHALL cover: prefilled with 0x00,0x80,0xFF, three symb_req -> duty 0, 32, 63 each one clock after its pulse.
REQ-035 SHALL cover: push 16 samples with in_valid held -> in_ready=0, fill_level=16, 17th sample not stored.
REQ-036 SHALL cover: RUN, FIFO drained, symb_req -> underrun=1, playing=0, duty=32 (macro off) or last duty, e.g. 63 (macro on).
REQ-037 SHALL cover: underrun_clr and new underrun in same cycle -> underrun stays 1; underrun_clr alone -> 0 next cycle.
REQ-038 SHALL cover: rst pulsed with fill_level=10 in RUN -> fill_level=0, playing=0, duty=32, in_ready=1.

Source files
------------

// File: rtl/am_sample_feeder.sv
// Audio sample buffer feeding an AM PWM modulator: prefills a FIFO, then pops one
// sample per symbol tick into duty. Optional macro AM_FEEDER_HOLD_LAST_EN holds last duty when idle.
module am_sample_feeder #(
  parameter int AM_PWM_STEPS = 64,
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PREFILL      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              symb_req,
  output logic [$clog2(AM_PWM_STEPS)-1:0]   duty,
  output logic                              playing,
  output logic                              underrun,
  input  logic                              underrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]       fill_level
);

  localparam int DUTY_W = $clog2(AM_PWM_STEPS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [DUTY_W-1:0] MID_DUTY = DUTY_W'(AM_PWM_STEPS / 2);

  // Input handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on the registered count, never on in_valid.
  typedef enum logic {ST_PREFILL = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push, pop, empty, starve;
  logic [DUTY_W-1:0]     idle_duty;

  assign in_ready   = (count != CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push       = in_valid && in_ready;
  assign pop        = (state == ST_RUN) && symb_req && !empty;
  assign starve     = (state == ST_RUN) && symb_req && empty;
  assign playing    = (state == ST_RUN);
  assign fill_level = count;

`ifdef AM_FEEDER_HOLD_LAST_EN
  assign idle_duty = duty;
`else
  assign idle_duty = MID_DUTY;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PREFILL: if (count >= CNT_W'(PREFILL)) state_nxt = ST_RUN;
      ST_RUN:     if (starve) state_nxt = ST_PREFILL;
      default:    state_nxt = ST_PREFILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_PREFILL;
    else     state <= state_nxt;
  end

  // Storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Duty changes only on a symbol tick; the top DUTY_W bits of the sample are the step count.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= MID_DUTY;
    end else if (symb_req) begin
      if (pop) duty <= mem[rd_ptr][DATA_WIDTH-1 -: DUTY_W];
      else     duty <= idle_duty;
    end
  end

  // A fresh starvation event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)               underrun <= 1'b0;
    else if (starve)       underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

endmodule

// File: tb/tb_am_sample_feeder.sv
// Directed bench for am_sample_feeder: driver queues expected duty per symbol tick,
// a negedge monitor compares duty one clock after each tick.
module tb_am_sample_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       symb_req = 1'b0;
  logic [5:0] duty;
  logic       playing;
  logic       underrun;
  logic       underrun_clr = 1'b0;
  logic [4:0] fill_level;

  always #5 clk = ~clk;

  am_sample_feeder #(
    .AM_PWM_STEPS(64), .DATA_WIDTH(8), .FIFO_DEPTH(16), .PREFILL(8)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .symb_req(symb_req), .duty(duty), .playing(playing), .underrun(underrun),
    .underrun_clr(underrun_clr), .fill_level(fill_level)
  );

  logic [5:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic       sreq_d = 1'b0;
  logic [5:0] mon_exp;
  logic [5:0] last_exp = 6'd32;

  // Monitor: duty must reflect a tick one clock after the tick was sampled.
  always @(posedge clk) sreq_d <= symb_req && !rst;

  always @(negedge clk) begin
    if (sreq_d) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL duty_unexpected: duty=%0d with no expected value queued", duty);
      end else begin
        mon_exp = exp_q.pop_front();
        if (duty !== mon_exp) begin
          n_fail++;
          $display("FAIL duty: got %0d expected %0d at %0t", duty, mon_exp, $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] idle();
`ifdef AM_FEEDER_HOLD_LAST_EN
    return last_exp;
`else
    return 6'd32;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic symb(input logic [5:0] e);
    exp_q.push_back(e);
    last_exp = e;
    symb_req = 1'b1;
    @(negedge clk);
    symb_req = 1'b0;
  endtask

  task automatic push_symb(input logic [7:0] d, input logic [5:0] e);
    in_valid = 1'b1;
    in_data  = d;
    symb(e);
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
    last_exp = 6'd32;
  endtask

  logic [7:0] run_a [7] = '{8'h40, 8'h10, 8'hC4, 8'h7F, 8'h04, 8'h20, 8'h08};
  logic [7:0] run_b [7] = '{8'h08, 8'h14, 8'h3C, 8'h9A, 8'hE0, 8'h55, 8'h02};
  logic [5:0] drain_a [5] = '{6'd4, 6'd49, 6'd31, 6'd1, 6'd8};
  logic [5:0] drain_b [8] = '{6'd63, 6'd2, 6'd5, 6'd15, 6'd38, 6'd56, 6'd21, 6'd0};

  initial begin
    @(negedge clk);
    do_reset(2);
    check("rst_fill", fill_level, 0);
    check("rst_ready", in_ready, 1);
    check("rst_playing", playing, 0);
    check("rst_underrun", underrun, 0);
    check("rst_duty", duty, 32);

    // Prefill threshold: 7 samples do not start playout.
    push(8'h00); push(8'h80); push(8'hFF);
    for (int i = 0; i < 4; i++) push(run_a[i]);
    symb(idle());
    check("pre7_playing", playing, 0);
    check("pre7_fill", fill_level, 7);
    push(run_a[4]);
    check("pre8_fill", fill_level, 8);
    check("pre8_playing_same", playing, 0);
    tick(1);
    check("pre8_playing_next", playing, 1);

    symb(6'd0);  tick(1);
    symb(6'd32); tick(1);
    symb(6'd63); tick(1);
    check("run3_fill", fill_level, 5);
    check("run3_playing", playing, 1);

    // Push and pop in the same cycle.
    push_symb(run_a[5], 6'd16);
    check("pushpop_fill", fill_level, 5);
    for (int i = 0; i < 5; i++) begin
      symb(drain_a[i]);
      tick(1);
    end
    check("drain_fill", fill_level, 0);
    check("drain_playing", playing, 1);
    check("drain_underrun", underrun, 0);

    // Starve with a simultaneous push: the push must not satisfy the tick.
    push_symb(8'hFC, idle());
    check("starve_underrun", underrun, 1);
    check("starve_playing", playing, 0);
    check("starve_fill", fill_level, 1);

    for (int i = 0; i < 7; i++) push(run_b[i]);
    tick(1);
    check("refill_playing", playing, 1);
    for (int i = 0; i < 8; i++) begin
      symb(drain_b[i]);
      tick(1);
    end
    check("drain2_fill", fill_level, 0);

    underrun_clr = 1'b1;
    symb(idle());
    underrun_clr = 1'b0;
    check("clr_vs_starve_underrun", underrun, 1);
    check("clr_vs_starve_playing", playing, 0);
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    check("clr_alone_underrun", underrun, 0);

    // Fill to capacity with in_valid held through a 17th sample.
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(i * 8 + 3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("full_fill", fill_level, 16);
    check("full_ready", in_ready, 0);
    tick(1);
    check("full_playing", playing, 1);
    for (int i = 0; i < 16; i++) begin
      symb(6'((i * 8 + 3) >> 2));
      tick(1);
    end
    check("full_drain_fill", fill_level, 0);

    // Reset mid-operation discards buffered samples.
    for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
    check("mid_fill", fill_level, 10);
    check("mid_playing", playing, 1);
    do_reset(2);
    check("mid_rst_fill", fill_level, 0);
    check("mid_rst_playing", playing, 0);
    check("mid_rst_duty", duty, 32);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_underrun", underrun, 0);
    symb(idle());
    check("post_rst_fill", fill_level, 0);

    tick(3);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
